keypad_matrix_responder: RTL

// - Device side of the 4x4 keypad matrix: watches the scanner's column drive (col) and

---
 rtl/keypad_pkg.sv | 23 ++
 rtl/keypad_bounce_lfsr.sv | 30 +++
 rtl/keypad_matrix_responder.sv | 127 ++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad matrix responder.
// Key code layout is {row[1:0], col[1:0]}; NO_KEY is the idle row return.
package keypad_pkg;

    typedef logic [3:0] key_code_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESS   = 2'd1,
        RELEASE = 2'd2
    } resp_state_t;

    localparam key_code_t NO_KEY = 4'hF;

    function automatic logic [1:0] key_row(input key_code_t k);
        return k[3:2];
    endfunction

    function automatic logic [1:0] key_col(input key_code_t k);
        return k[1:0];
    endfunction

endpackage

// File: rtl/keypad_bounce_lfsr.sv
// Pseudo-random contact source used to emulate switch bounce.
// 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 16'hACE1.
module keypad_bounce_lfsr
    import keypad_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic contact
);

    localparam logic [15:0] SEED = 16'hACE1;

    logic [15:0] lfsr;
    logic        fb;

    assign fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    // Step the sequence once per enabled clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr <= SEED;
        end else if (enable) begin
            lfsr <= {lfsr[14:0], fb};
        end
    end

    assign contact = lfsr[0];

endmodule

// File: rtl/keypad_matrix_responder.sv
// Emulates a held key on a 4x4 active-low matrix for a fixed hold/release time.
// Optional switch-bounce emulation is enabled by defining KEYPAD_BOUNCE_EN.
module keypad_matrix_responder
    import keypad_pkg::*;
#(
    parameter int HOLD_CYCLES    = 2_000_000,
    parameter int RELEASE_CYCLES = 1_000_000,
    parameter int BOUNCE_CYCLES  = 50_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] col,
    output logic [3:0] fila,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       key_ready,
    output logic       busy,
    output logic       done
);

    localparam int MAX_CYCLES = (HOLD_CYCLES > RELEASE_CYCLES) ?
                                HOLD_CYCLES : RELEASE_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);

    if (BOUNCE_CYCLES >= HOLD_CYCLES || BOUNCE_CYCLES >= RELEASE_CYCLES) begin : g_bad_cfg
        $error("bounce window must be shorter than hold and release");
    end

    resp_state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    key_code_t     key, key_n;
    logic          done_n;
    logic          hold_last;
    logic          rel_last;
    logic          key_on;
    logic          col_hit;

    assign hold_last = (cnt == CW'(HOLD_CYCLES - 1));
    assign rel_last  = (cnt == CW'(RELEASE_CYCLES - 1));

    // State, counter, latched key and done pulse registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            key   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            key   <= key_n;
            done  <= done_n;
        end
    end

    // Next-state: accept in IDLE, time the press, then time the release.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        key_n   = key;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (key_valid) begin
                    key_n   = key_code;
                    cnt_n   = '0;
                    state_n = PRESS;
                end
            end
            PRESS: begin
                if (hold_last) begin
                    cnt_n   = '0;
                    state_n = RELEASE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            RELEASE: begin
                if (rel_last) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

`ifdef KEYPAD_BOUNCE_EN
    logic lfsr_bit;
    logic in_window;

    keypad_bounce_lfsr u_bounce (
        .clk     (clk),
        .reset   (reset),
        .enable  (1'b1),
        .contact (lfsr_bit)
    );

    assign in_window = (cnt < CW'(BOUNCE_CYCLES));

    // Contact chatters at the start of both press and release.
    always_comb begin
        key_on = 1'b0;
        if (state == PRESS) begin
            key_on = in_window ? lfsr_bit : 1'b1;
        end else if (state == RELEASE) begin
            key_on = in_window & lfsr_bit;
        end
    end
`else
    assign key_on = (state == PRESS);
`endif

    // The switch closes the row only while its column is driven low.
    assign col_hit = ~col[key_col(key)];
    assign fila    = (key_on && col_hit) ? ~(4'b0001 << key_row(key)) : NO_KEY;

    assign key_ready = (state == IDLE);
    assign busy      = (state == PRESS) || (state == RELEASE);

endmodule
